init_seq_ctrl: RTL and testbench
================================

Name: init_seq_ctrl

Overview:
- Power-up sequencer for the board-level resources: PLL, DDR controller, HDMI transmitter config and the video/app pipeline.
- Replaces the free-running reset counter with an ordered FSM:
  - waits for stable PLL lock;
  - pulses DDR reset;
  - waits for DDR calibration, then triggers HDMI configuration;
  - releases the application reset only when both are up.
- Detects init faults and retries a bounded number of times.

Parameters:
- STABLE_CYC, 1024: consecutive locked cycles required before DDR reset sequencing.
- DDR_RST_CYC, 256: cycles ddr_rstn is held low.
- TIMEOUT_CYC, 2000000: max wait for ddr_idone / hdmi_idone (200 ms at 10 MHz).
- MAX_RETRY, 3: FAULT→DDR_RST retries before latching fault.
- CNT_W, 24: timer width; must hold max(STABLE_CYC, DDR_RST_CYC, TIMEOUT_CYC).

Ports:
- clk  in  1  10 MHz system clock.
- rstn  in  1  synchronous active-low reset.
- pll_lock  in  1  PLL lock, asynchronous.
- ddr_idone  in  1  DDR init/calibration done, asynchronous.
- hdmi_idone  in  1  HDMI config done, asynchronous.
- ddr_rstn  out  1  DDR controller reset, active-low.
- hdmi_cfg_start  out  1  one-cycle start pulse to the HDMI config engine.
- app_rstn  out  1  pipeline reset, active-low.
- init_done  out  1  system up.
- fault  out  1  init failed after all retries; sticky.
- retry_cnt  out  2  retries used so far.
- state_o  out  3  current state encoding, for debug/LED.

Behaviour:
- Input synchronisation:
  - pll_lock, ddr_idone and hdmi_idone each pass through a 2-flop synchroniser (_s signals); 2-cycle latency.
  - The FSM sees only the _s signals.
- Reset values (rstn=0, synchronous):
  - state=IDLE, timer=0, retry_cnt=0.
  - ddr_rstn=0, app_rstn=0, hdmi_cfg_start=0, init_done=0, fault=0.
  - Synchroniser flops cleared.
- Output timing: all outputs are registered and computed from next-state, so they change on the same edge the state is entered.
- States and encoding: IDLE=0, PLL_STABLE=1, DDR_RST=2, DDR_WAIT=3, HDMI_CFG=4, RUN=5, FAULT=6.
- IDLE:
  - All resets asserted.
  - pll_lock_s=1 → PLL_STABLE, timer loaded STABLE_CYC-1.
- PLL_STABLE:
  - Timer decrements; at timer==0 → DDR_RST, timer loaded DDR_RST_CYC-1.
  - Occupies exactly STABLE_CYC cycles.
- DDR_RST:
  - ddr_rstn=0 for exactly DDR_RST_CYC cycles, then → DDR_WAIT, timer loaded TIMEOUT_CYC-1.
- DDR_WAIT:
  - ddr_rstn=1.
  - ddr_idone_s=1 → HDMI_CFG, timer reloaded TIMEOUT_CYC-1.
  - Timer expiry → FAULT.
  - Done and expiry in the same cycle: done wins.
- HDMI_CFG:
  - hdmi_cfg_start=1 only on the first cycle in the state.
  - hdmi_idone_s=1 → RUN; timer expiry → FAULT; done wins on collision.
  - hdmi_idone_s already high on entry is accepted on the next cycle; the pulse is still issued.
- RUN:
  - app_rstn=1, init_done=1.
  - Drop of ddr_idone_s or hdmi_idone_s → FAULT.
- FAULT:
  - ddr_rstn=0, app_rstn=0, init_done=0.
  - If retry_cnt<MAX_RETRY: retry_cnt++ and → DDR_RST next cycle.
  - Otherwise stay in FAULT with fault=1 until rstn.
- PLL loss:
  - pll_lock_s=0 in any state other than IDLE or terminal FAULT → IDLE next edge.
  - Clears the timer and retry_cnt; all resets asserted.
  - Highest priority over every other transition.
- Overall latency: ddr_rstn rises exactly 3+STABLE_CYC+DDR_RST_CYC edges after the first edge sampling pll_lock=1 (2 sync + 1 IDLE exit).

Optional Feature:
- Macro: INIT_SEQ_TIMEOUT_EN.
- Defined: DDR_WAIT/HDMI_CFG timeouts, FAULT retry path and fault output behave as above.
- Undefined:
  - Timeouts removed; DDR_WAIT and HDMI_CFG wait indefinitely.
  - RUN-state done-drop still enters FAULT, which always retries (no limit); fault tied 0.

Decomposition:
- Package init_seq_pkg: state enum (3-bit encodings above) and the localparam width for retry_cnt.
- Sub-module seq_timer: loadable down-counter (clk, rstn, load, load_val[CNT_W], en, zero), instantiated once.
- Synchronisers: inline generate of 2-flop chains.

Test Plan (sim params STABLE_CYC=8, DDR_RST_CYC=4, TIMEOUT_CYC=32, MAX_RETRY=2):
- Nominal: pll_lock=1 at cycle 0, ddr_idone at cycle 20, hdmi_idone 5 cycles after the hdmi_cfg_start pulse → ddr_rstn rises at edge 15; exactly one hdmi_cfg_start pulse; app_rstn=init_done=1 in RUN.
- PLL glitch: pll_lock low for 3 cycles during PLL_STABLE cycle 5 → return to IDLE; full 8-cycle stable count restarts; ddr_rstn stays 0 throughout.
- DDR timeout: ddr_idone never asserted → FAULT after 32 DDR_WAIT cycles; 2 retries (retry_cnt 1, then 2); then fault=1 sticky, state_o=6.
- Collision: ddr_idone_s rises on the same cycle the timer hits 0 → HDMI_CFG, not FAULT.
- RUN loss: hdmi_idone dropped while in RUN → FAULT, init_done=0 and app_rstn=0 on the same edge, then retry with retry_cnt=1.
- Reset mid-operation: rstn=0 for 1 cycle during HDMI_CFG → all outputs at reset values next edge; full sequence replays with retry_cnt=0.

Source files
------------

// File: rtl/init_seq_pkg.sv
// ---------------------------------------------------------------------------
// init_seq_pkg
// Shared types for the power-up sequencer: the FSM state encoding (also
// exported on state_o for debug LEDs) and the width of the retry counter.
// ---------------------------------------------------------------------------
package init_seq_pkg;

    localparam int RETRY_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLL_STABLE = 3'd1,
        ST_DDR_RST    = 3'd2,
        ST_DDR_WAIT   = 3'd3,
        ST_HDMI_CFG   = 3'd4,
        ST_RUN        = 3'd5,
        ST_FAULT      = 3'd6
    } state_e;

endpackage

// File: rtl/init_seq_ctrl_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Loadable down-counter shared by every timed phase of the sequencer.
// A load takes priority over counting; counting stops at zero.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset (count cleared)
//   load       - load load_val on the next edge
//   load_val   - value to load
//   en         - decrement enable
//   zero       - high while the count is zero
// ---------------------------------------------------------------------------
module seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/init_seq_ctrl.sv
// ---------------------------------------------------------------------------
// init_seq_ctrl
// Ordered power-up sequencer: waits for a stable PLL lock, pulses the DDR
// reset, waits for DDR calibration, kicks off HDMI configuration and finally
// releases the application reset. Init faults are retried.
//
// Build option INIT_SEQ_TIMEOUT_EN:
//   defined   - DDR_WAIT / HDMI_CFG time out into FAULT, FAULT retries at
//               most MAX_RETRY times and then latches the sticky fault output.
//   undefined - no timeouts, FAULT (reached only from RUN) always retries,
//               fault is tied low.
//
// Ports:
//   clk            - 10 MHz system clock
//   rstn           - synchronous active-low reset
//   pll_lock       - PLL lock (asynchronous)
//   ddr_idone      - DDR init/calibration done (asynchronous)
//   hdmi_idone     - HDMI config done (asynchronous)
//   ddr_rstn       - DDR controller reset, active-low
//   hdmi_cfg_start - one-cycle start pulse to the HDMI config engine
//   app_rstn       - pipeline reset, active-low
//   init_done      - system up
//   fault          - init failed after all retries (sticky)
//   retry_cnt      - retries used so far
//   state_o        - current state encoding
// ---------------------------------------------------------------------------
module init_seq_ctrl
    import init_seq_pkg::*;
#(
    parameter int STABLE_CYC  = 1024,
    parameter int DDR_RST_CYC = 256,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 24
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pll_lock,
    input  logic               ddr_idone,
    input  logic               hdmi_idone,
    output logic               ddr_rstn,
    output logic               hdmi_cfg_start,
    output logic               app_rstn,
    output logic               init_done,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

`ifdef INIT_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0]   STABLE_LOAD  = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   DDR_RST_LOAD = CNT_W'(DDR_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    // ---------------------------------------------------------------------
    // Input synchronisers (bit 0 pll_lock, bit 1 ddr_idone, bit 2 hdmi_idone)
    // ---------------------------------------------------------------------
    logic [2:0] async_in;
    logic [2:0] sync_s;
    logic       pll_lock_s;
    logic       ddr_idone_s;
    logic       hdmi_idone_s;

    assign async_in = {hdmi_idone, ddr_idone, pll_lock};

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_sync
            logic meta_q;
            logic sync_q;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= async_in[g];
                    sync_q <= meta_q;
                end
            end

            assign sync_s[g] = sync_q;
        end
    endgenerate

    assign pll_lock_s   = sync_s[0];
    assign ddr_idone_s  = sync_s[1];
    assign hdmi_idone_s = sync_s[2];

    // ---------------------------------------------------------------------
    // Shared phase timer
    // ---------------------------------------------------------------------
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (1'b1),
        .zero     (timer_zero)
    );

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               ddr_rstn_q, ddr_rstn_d;
    logic               hdmi_cfg_start_q, hdmi_cfg_start_d;
    logic               app_rstn_q, app_rstn_d;
    logic               init_done_q, init_done_d;
    logic               fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            retry_cnt_q      <= '0;
            ddr_rstn_q       <= 1'b0;
            hdmi_cfg_start_q <= 1'b0;
            app_rstn_q       <= 1'b0;
            init_done_q      <= 1'b0;
            fault_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            retry_cnt_q      <= retry_cnt_d;
            ddr_rstn_q       <= ddr_rstn_d;
            hdmi_cfg_start_q <= hdmi_cfg_start_d;
            app_rstn_q       <= app_rstn_d;
            init_done_q      <= init_done_d;
            fault_q          <= fault_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // Terminal FAULT (retries used up) is the one non-IDLE state that ignores
    // PLL loss, so the fault indication survives until an external reset.
    logic retry_exhausted;
    logic pll_loss;

    assign retry_exhausted = TIMEOUT_EN && (retry_cnt_q >= RETRY_LIMIT);
    assign pll_loss = !pll_lock_s && (state_q != ST_IDLE) &&
                      !((state_q == ST_FAULT) && retry_exhausted);

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        timer_load  = 1'b0;
        timer_val   = '0;

        if (pll_loss) begin
            state_d     = ST_IDLE;
            retry_cnt_d = '0;
            timer_load  = 1'b1;
            timer_val   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pll_lock_s) begin
                        state_d    = ST_PLL_STABLE;
                        timer_load = 1'b1;
                        timer_val  = STABLE_LOAD;
                    end
                end
                ST_PLL_STABLE: begin
                    if (timer_zero) begin
                        state_d    = ST_DDR_RST;
                        timer_load = 1'b1;
                        timer_val  = DDR_RST_LOAD;
                    end
                end
                ST_DDR_RST: begin
                    if (timer_zero) begin
                        state_d    = ST_DDR_WAIT;
                        timer_load = 1'b1;
                        timer_val  = TIMEOUT_LOAD;
                    end
                end
                // A done seen on the expiry cycle wins over the timeout.
                ST_DDR_WAIT: begin
                    if (ddr_idone_s) begin
                        state_d    = ST_HDMI_CFG;
                        timer_load = 1'b1;
                        timer_val  = TIMEOUT_LOAD;
                    end else if (TIMEOUT_EN && timer_zero) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_HDMI_CFG: begin
                    if (hdmi_idone_s) begin
                        state_d = ST_RUN;
                    end else if (TIMEOUT_EN && timer_zero) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_RUN: begin
                    if (!ddr_idone_s || !hdmi_idone_s) begin
                        state_d = ST_FAULT;
                    end
                end
                // Without the limit the count saturates rather than wrapping.
                ST_FAULT: begin
                    if (!retry_exhausted) begin
                        if (retry_cnt_q != '1) begin
                            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        end
                        state_d    = ST_DDR_RST;
                        timer_load = 1'b1;
                        timer_val  = DDR_RST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output logic, decoded from the next state so outputs change on the
    // same edge the state is entered
    // ---------------------------------------------------------------------
    always_comb begin
        ddr_rstn_d       = (state_d == ST_DDR_WAIT) || (state_d == ST_HDMI_CFG) ||
                           (state_d == ST_RUN);
        hdmi_cfg_start_d = (state_d == ST_HDMI_CFG) && (state_q != ST_HDMI_CFG);
        app_rstn_d       = (state_d == ST_RUN);
        init_done_d      = (state_d == ST_RUN);
        fault_d          = TIMEOUT_EN && (state_d == ST_FAULT) &&
                           (retry_cnt_d >= RETRY_LIMIT);
    end

    assign ddr_rstn       = ddr_rstn_q;
    assign hdmi_cfg_start = hdmi_cfg_start_q;
    assign app_rstn       = app_rstn_q;
    assign init_done      = init_done_q;
    assign fault          = fault_q;
    assign retry_cnt      = retry_cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_init_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_init_seq_ctrl
// Bench for init_seq_ctrl with small sequencing parameters. A behavioural
// model counts elapsed cycles per phase and predicts every output after each
// clock edge; directed scenarios add explicit latency/boundary checks and a
// randomized phase drives held random input levels and short resets.
// ---------------------------------------------------------------------------
module tb_init_seq_ctrl;

    localparam int STABLE = 8;
    localparam int DRST   = 4;
    localparam int TMO    = 32;
    localparam int MAXR   = 2;

`ifdef INIT_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       ddr_idone = 1'b0;
    logic       hdmi_idone = 1'b0;
    logic       ddr_rstn;
    logic       hdmi_cfg_start;
    logic       app_rstn;
    logic       init_done;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    always #50 clk = ~clk;

    init_seq_ctrl #(
        .STABLE_CYC  (STABLE),
        .DDR_RST_CYC (DRST),
        .TIMEOUT_CYC (TMO),
        .MAX_RETRY   (MAXR),
        .CNT_W       (24)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pll_lock       (pll_lock),
        .ddr_idone      (ddr_idone),
        .hdmi_idone     (hdmi_idone),
        .ddr_rstn       (ddr_rstn),
        .hdmi_cfg_start (hdmi_cfg_start),
        .app_rstn       (app_rstn),
        .init_done      (init_done),
        .fault          (fault),
        .retry_cnt      (retry_cnt),
        .state_o        (state_o)
    );

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model: phase number, cycles spent in it, retries used,
    // and a two-deep delay line standing in for the synchronisers.
    int         m_phase = 0;
    int         m_elapsed = 0;
    int         m_retries = 0;
    logic [2:0] m_meta = '0;
    logic [2:0] m_sync = '0;
    logic       m_ddr_rstn = 0, m_start = 0, m_app = 0, m_done = 0, m_fault = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input logic r, input logic p, input logic d, input logic h);
        int  prev;
        bit  pll_s, ddr_s, hdmi_s, terminal;
        if (!r) begin
            m_phase = 0; m_elapsed = 0; m_retries = 0;
            m_meta = '0; m_sync = '0;
        end else begin
            pll_s  = m_sync[0];
            ddr_s  = m_sync[1];
            hdmi_s = m_sync[2];
            m_sync = m_meta;
            m_meta = {h, d, p};
            prev = m_phase;
            terminal = TO_EN && (m_phase == 6) && (m_retries >= MAXR);
            m_elapsed++;
            if (!pll_s && m_phase != 0 && !terminal) begin
                m_phase = 0;
                m_retries = 0;
            end else begin
                case (m_phase)
                    0: if (pll_s) m_phase = 1;
                    1: if (m_elapsed == STABLE) m_phase = 2;
                    2: if (m_elapsed == DRST) m_phase = 3;
                    3: if (ddr_s) m_phase = 4;
                       else if (TO_EN && m_elapsed == TMO) m_phase = 6;
                    4: if (hdmi_s) m_phase = 5;
                       else if (TO_EN && m_elapsed == TMO) m_phase = 6;
                    5: if (!ddr_s || !hdmi_s) m_phase = 6;
                    6: if (!terminal) begin
                           if (m_retries < 3) m_retries++;
                           m_phase = 2;
                       end
                    default: m_phase = 0;
                endcase
            end
            if (m_phase != prev) m_elapsed = 0;
        end
        m_ddr_rstn = (m_phase == 3) || (m_phase == 4) || (m_phase == 5);
        m_start    = r && (m_phase == 4) && (prev != 4);
        m_app      = (m_phase == 5);
        m_done     = (m_phase == 5);
        m_fault    = TO_EN && (m_phase == 6) && (m_retries >= MAXR);
    endtask

    function automatic logic [9:0] dutVec();
        return {ddr_rstn, hdmi_cfg_start, app_rstn, init_done, fault, retry_cnt, state_o};
    endfunction

    task automatic applyStimulus(input logic r, input logic p, input logic d, input logic h);
        logic [9:0] exp_vec;
        rstn = r; pll_lock = p; ddr_idone = d; hdmi_idone = h;
        @(posedge clk);
        modelStep(r, p, d, h);
        edge_no++;
        #1;
        exp_vec = {m_ddr_rstn, m_start, m_app, m_done, m_fault,
                   m_retries[1:0], m_phase[2:0]};
        checkOutput("model_outputs", 32'(dutVec()), 32'(exp_vec));
        @(negedge clk);
    endtask

    task automatic doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", 32'(dutVec()), 32'd0);
        edge_no = 0;
    endtask

    initial begin
        int  rise_edge, pulses, start_edge, stable_cnt, ddr_hi, st47, saw6;
        bit  seen;
        logic rp, rd, rh;
        int  hp, hd, hh;

        @(negedge clk);
        $display("[TB] start, timeout feature = %0d", TO_EN);

        // ---------------- Nominal bring-up ----------------
        doReset();
        rise_edge = -1; pulses = 0; start_edge = -1;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b1, 1'b1, k >= 20, (start_edge > 0) && (k >= start_edge + 5));
            if (ddr_rstn && rise_edge < 0) rise_edge = edge_no;
            if (hdmi_cfg_start) begin
                pulses++;
                if (start_edge < 0) start_edge = edge_no;
            end
        end
        checkOutput("nom_ddr_rise_edge", rise_edge, 3 + STABLE + DRST);
        checkOutput("nom_cfg_pulses", pulses, 1);
        checkOutput("nom_run_state", state_o, 5);
        checkOutput("nom_run_outs", {app_rstn, init_done, fault}, 3'b110);

        // ---------------- RUN loss ----------------
        seen = 0;
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, k > 4);
            if (!seen && state_o == 3'd6) begin
                seen = 1;
                checkOutput("runloss_outs_on_fault", {init_done, app_rstn, ddr_rstn}, 3'b000);
            end
        end
        checkOutput("runloss_fault_seen", seen, 1);
        checkOutput("runloss_retry", retry_cnt, 1);
        checkOutput("runloss_back_in_run", state_o, 5);

        // ---------------- PLL glitch ----------------
        doReset();
        ddr_hi = 0; stable_cnt = 0; rise_edge = -1;
        for (int k = 1; k <= 26; k++) begin
            applyStimulus(1'b1, !(k >= 7 && k <= 9), 1'b0, 1'b0);
            if (k <= 23 && ddr_rstn) ddr_hi++;
            if (k >= 10 && state_o == 3'd1) stable_cnt++;
            if (ddr_rstn && rise_edge < 0) rise_edge = edge_no;
        end
        checkOutput("glitch_ddr_held_low", ddr_hi, 0);
        checkOutput("glitch_stable_restart", stable_cnt, STABLE);
        checkOutput("glitch_ddr_rise_edge", rise_edge, (10 - 1) + 3 + STABLE + DRST);

`ifdef INIT_SEQ_TIMEOUT_EN
        // ---------------- DDR timeout with retries ----------------
        doReset();
        for (int k = 1; k <= 160; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("timeout_fault", fault, 1);
        checkOutput("timeout_state", state_o, 6);
        checkOutput("timeout_retry", retry_cnt, MAXR);
        for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("timeout_sticky", {fault, state_o}, {1'b1, 3'd6});
`endif

        // ---------------- Done / expiry collision ----------------
        doReset();
        st47 = -1; saw6 = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b1, 1'b1, k >= 45, 1'b0);
            if (edge_no == 47) st47 = state_o;
            if (state_o == 3'd6) saw6++;
        end
        checkOutput("collision_state", st47, 4);
        checkOutput("collision_no_fault", saw6, 0);

        // ---------------- Reset during HDMI_CFG ----------------
        checkOutput("midreset_pre_state", state_o, 4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("midreset_outputs", 32'(dutVec()), 32'd0);
        edge_no = 0; rise_edge = -1; start_edge = -1;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, (start_edge > 0) && (k >= start_edge + 2));
            if (ddr_rstn && rise_edge < 0) rise_edge = edge_no;
            if (hdmi_cfg_start && start_edge < 0) start_edge = edge_no;
        end
        checkOutput("replay_ddr_rise_edge", rise_edge, 3 + STABLE + DRST);
        checkOutput("replay_run", {state_o, retry_cnt}, {3'd5, 2'd0});

        // ---------------- Randomized levels ----------------
        doReset();
        rp = 1; rd = 0; rh = 0; hp = 0; hd = 0; hh = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hp == 0) begin rp = ($urandom_range(99) < 85); hp = $urandom_range(60, 1); end
            if (hd == 0) begin rd = ($urandom_range(99) < 70); hd = $urandom_range(80, 1); end
            if (hh == 0) begin rh = ($urandom_range(99) < 70); hh = $urandom_range(80, 1); end
            hp--; hd--; hh--;
            applyStimulus(!($urandom_range(499) == 0), rp, rd, rh);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
